// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared UART definitions used by the transmitter (uart_tx_buf) and the
//   receiver (uart_rcv): transmit FSM state type, default baud divisor and
//   frame length, plus a helper that builds the on-wire frame for one byte.
// -----------------------------------------------------------------------------
package uart_pkg;

   // clk cycles per bit; the receiver counts baud_end = UART_BAUD_DIV-1
   localparam int UART_BAUD_DIV   = 2604;
   // start + 8 data + stop
   localparam int UART_FRAME_BITS = 10;

   typedef enum logic {
      IDLE = 1'b0,
      XMIT = 1'b1
   } tx_state_t;

   // Frame as shifted out LSB first: start bit (0) in bit 0, stop bit (1) on top.
   function automatic logic [UART_FRAME_BITS-1:0] uart_frame(input logic [7:0] data);
      return {1'b1, data, 1'b0};
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Small synchronous FIFO queuing bytes for the UART transmitter.
//   Ports:
//     clk   in   system clock
//     rst   in   asynchronous active-high reset (empties the FIFO)
//     push  in   write din (ignored while full)
//     pop   in   advance the read pointer (ignored while empty)
//     din   in   write data
//     dout  out  head of the FIFO, valid whenever empty=0
//     full  out  FIFO holds DEPTH entries
//     empty out  FIFO holds no entries
//   full/empty come from the registered count only, so a pop in the same cycle
//   never admits a push into a full FIFO.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Head is read combinationally so the transmitter can load it on the pop edge.
   assign dout = mem_reg[rd_ptr_reg];

   // Storage carries no reset; stale contents are unreachable once count is 0.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_reg[wr_ptr_reg] <= din;
      end
   end

   // Pointers are power-of-two sized and wrap on their own.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_buf.sv
// -----------------------------------------------------------------------------
// uart_tx_buf
//   Buffered 8N1 UART transmitter. Bytes pushed with trmt are queued in a
//   FIFO_DEPTH-entry FIFO and sent back-to-back with no idle gap between frames.
//   Ports:
//     clk          in   system clock
//     rst          in   asynchronous active-high reset
//     trmt         in   push request, tx_data captured on this cycle
//     tx_data      in   byte to queue
//     clr_tx_done  in   clears the sticky tx_done flag
//     TX           out  serial line, idles high, driven straight from a flop
//     tx_busy      out  a frame is being shifted out
//     tx_done      out  sticky: a frame finished with nothing left queued
//     fifo_full    out  queue is full, further pushes are dropped
// -----------------------------------------------------------------------------
module uart_tx_buf
   import uart_pkg::*;
#(
   parameter int BAUD_DIV   = UART_BAUD_DIV,  // clk cycles per bit, >= 2
   parameter int FIFO_DEPTH = 4               // power of 2, >= 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   input  logic       clr_tx_done,
   output logic       TX,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       fifo_full
);

   localparam int             BW        = $clog2(BAUD_DIV);
   localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [3:0]     BIT_LAST  = 4'(UART_FRAME_BITS - 1);

   tx_state_t                     state_reg;
   logic [BW-1:0]                 baud_cnt_reg;
   logic [3:0]                    bit_cnt_reg;
   logic [UART_FRAME_BITS-1:0]    shift_reg;
   logic                          tx_busy_reg;
   logic                          tx_done_reg;

   logic       fifo_empty;
   logic       fifo_pop;
   logic [7:0] fifo_dout;
   logic       push_ok;
   logic       bit_end;
   logic       frame_end;

   assign push_ok   = trmt && !fifo_full;
   assign bit_end   = (state_reg == XMIT) && (baud_cnt_reg == BAUD_LAST);
   // The last cycle of the stop bit is where bit_cnt would step to 10; acting
   // here keeps every frame exactly 10*BAUD_DIV cycles and lets the next start
   // bit follow the stop bit with no gap.
   assign frame_end = bit_end && (bit_cnt_reg == BIT_LAST);
   assign fifo_pop  = !fifo_empty && ((state_reg == IDLE) || frame_end);

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (trmt),
      .pop   (fifo_pop),
      .din   (tx_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         baud_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         shift_reg    <= '1;   // all ones keeps TX high
         tx_busy_reg  <= 1'b0;
         tx_done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (!fifo_empty) begin
                  shift_reg    <= uart_frame(fifo_dout);
                  baud_cnt_reg <= '0;
                  bit_cnt_reg  <= '0;
                  tx_busy_reg  <= 1'b1;
                  state_reg    <= XMIT;
               end
            end
            XMIT: begin
               if (frame_end) begin
                  baud_cnt_reg <= '0;
                  bit_cnt_reg  <= '0;
                  if (!fifo_empty) begin
                     shift_reg <= uart_frame(fifo_dout);
                  end else begin
                     shift_reg   <= '1;
                     tx_busy_reg <= 1'b0;
                     state_reg   <= IDLE;
                  end
               end else if (bit_end) begin
                  shift_reg    <= {1'b1, shift_reg[UART_FRAME_BITS-1:1]};
                  baud_cnt_reg <= '0;
                  bit_cnt_reg  <= bit_cnt_reg + 1'b1;
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase

         // Clearing beats setting when both land on the same edge.
         if (clr_tx_done || push_ok) begin
            tx_done_reg <= 1'b0;
         end else if (frame_end && fifo_empty) begin
            tx_done_reg <= 1'b1;
         end
      end
   end

   assign TX      = shift_reg[0];
   assign tx_busy = tx_busy_reg;
   assign tx_done = tx_done_reg;

endmodule

// File: tb/tb_uart_tx_buf.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buf
//   Directed bench for uart_tx_buf. A short baud divisor keeps runs small; a
//   bench-side serial decoder samples TX at mid-bit and rebuilds each frame.
// -----------------------------------------------------------------------------
module tb_uart_tx_buf;

   localparam int BD    = 16;
   localparam int DEPTH = 4;

   logic       clk         = 1'b0;
   logic       rst         = 1'b1;
   logic       trmt        = 1'b0;
   logic [7:0] tx_data     = 8'h00;
   logic       clr_tx_done = 1'b0;
   logic       TX;
   logic       tx_busy;
   logic       tx_done;
   logic       fifo_full;

   int total = 0;
   int bad   = 0;

   // decoder results
   logic [9:0] got [8];
   int         grab_w;
   bit         grab_done_seen;
   bit         grab_busy_low;

   always #5 clk = ~clk;

   uart_tx_buf #(
      .BAUD_DIV   (BD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .trmt        (trmt),
      .tx_data     (tx_data),
      .clr_tx_done (clr_tx_done),
      .TX          (TX),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .fifo_full   (fifo_full)
   );

   function automatic logic [9:0] exp_frame(input logic [7:0] b);
      return {1'b1, b, 1'b0};
   endfunction

   // Called at a negedge; returns one negedge later with trmt low again.
   task automatic push_byte(input logic [7:0] b);
      trmt    = 1'b1;
      tx_data = b;
      @(negedge clk);
      trmt    = 1'b0;
   endtask

   // Waits (bounded) for TX to fall, then samples nf frames at mid-bit.
   // Index n=0 is the first negedge showing the start bit. Optionally raises
   // clr_tx_done across the edge that ends the last frame.
   task automatic grab(input int nf, input bit clr_end);
      logic [3:0] bi;
      grab_w         = 0;
      grab_done_seen = 1'b0;
      grab_busy_low  = 1'b0;
      while (TX !== 1'b0 && grab_w < 4 * BD) begin
         @(negedge clk);
         grab_w++;
      end
      for (int f = 0; f < nf; f++) begin
         got[f] = '1;
         for (int n = 0; n < 10 * BD; n++) begin
            if (n % BD == BD / 2) begin
               bi = 4'(n / BD);
               got[f][bi] = TX;
            end
            if (tx_done === 1'b1) grab_done_seen = 1'b1;
            if (tx_busy !== 1'b1) grab_busy_low = 1'b1;
            if (clr_end && f == nf - 1 && n == 10 * BD - 1) clr_tx_done = 1'b1;
            @(negedge clk);
         end
      end
      clr_tx_done = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      total++; if (TX !== 1'b1)        begin bad++; $display("FAIL rst_tx got=%b exp=1", TX); end
      total++; if (tx_busy !== 1'b0)   begin bad++; $display("FAIL rst_busy got=%b exp=0", tx_busy); end
      total++; if (tx_done !== 1'b0)   begin bad++; $display("FAIL rst_done got=%b exp=0", tx_done); end
      total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", fifo_full); end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (TX !== 1'b1)      begin bad++; $display("FAIL idle_tx got=%b exp=1", TX); end
      total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", tx_busy); end
      $display("reset: released, line idle");
   endtask

   task automatic test_single;
      push_byte(8'hA5);
      total++; if (TX !== 1'b1) begin bad++; $display("FAIL single_early_tx got=%b exp=1", TX); end
      grab(1, 1'b0);
      total++; if (grab_w !== 1) begin bad++; $display("FAIL single_latency got=%0d exp=1", grab_w); end
      total++; if (got[0] !== 10'b1101001010) begin bad++; $display("FAIL single_frame got=%b exp=%b", got[0], 10'b1101001010); end
      total++; if (grab_done_seen !== 1'b0) begin bad++; $display("FAIL single_done_early got=1 exp=0"); end
      total++; if (grab_busy_low !== 1'b0)  begin bad++; $display("FAIL single_busy_drop got=1 exp=0"); end
      total++; if (tx_done !== 1'b1) begin bad++; $display("FAIL single_done got=%b exp=1", tx_done); end
      total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b exp=0", tx_busy); end
      $display("single: frame=%b", got[0]);
   endtask

   task automatic test_loopback;
      logic [7:0] lb [3];
      lb = '{8'h00, 8'hFF, 8'h55};
      for (int i = 0; i < 3; i++) begin
         push_byte(lb[i]);
         grab(1, 1'b0);
         total++; if (got[0][8:1] !== lb[i]) begin bad++; $display("FAIL loop_data got=%h exp=%h", got[0][8:1], lb[i]); end
         total++; if (got[0][0] !== 1'b0 || got[0][9] !== 1'b1) begin bad++; $display("FAIL loop_framing got=%b exp=1xxxxxxxx0", got[0]); end
         total++; if (tx_done !== 1'b1) begin bad++; $display("FAIL loop_done got=%b exp=1", tx_done); end
         $display("loopback: sent=%h rcv=%h", lb[i], got[0][8:1]);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] d [5];
      d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h99};
      push_byte(d[0]);
      fork
         grab(5, 1'b0);
         begin
            @(negedge clk);                 // first frame now on the line
            for (int i = 1; i < 5; i++) begin
               trmt    = 1'b1;
               tx_data = d[i];
               @(negedge clk);
               if (i == 3) begin
                  total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL b2b_full_3 got=%b exp=0", fifo_full); end
               end
            end
            trmt = 1'b0;
            total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL b2b_full_4 got=%b exp=1", fifo_full); end
         end
      join
      total++; if (grab_w !== 1) begin bad++; $display("FAIL b2b_latency got=%0d exp=1", grab_w); end
      for (int f = 0; f < 5; f++) begin
         total++; if (got[f] !== exp_frame(d[f])) begin bad++; $display("FAIL b2b_frame%0d got=%b exp=%b", f, got[f], exp_frame(d[f])); end
         $display("b2b: frame %0d data=%h", f, got[f][8:1]);
      end
      total++; if (grab_busy_low !== 1'b0)  begin bad++; $display("FAIL b2b_gap got=busy_dropped exp=contiguous"); end
      total++; if (grab_done_seen !== 1'b0) begin bad++; $display("FAIL b2b_done_early got=1 exp=0"); end
      total++; if (tx_done !== 1'b1)   begin bad++; $display("FAIL b2b_done got=%b exp=1", tx_done); end
      total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL b2b_full_end got=%b exp=0", fifo_full); end
   endtask

   task automatic test_overflow;
      logic [7:0] d [6];
      int zeros;
      d = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
      trmt    = 1'b1;
      tx_data = d[0];
      @(negedge clk);
      fork
         grab(5, 1'b0);
         begin
            for (int i = 1; i < 6; i++) begin
               tx_data = d[i];
               @(negedge clk);
               if (i == 3) begin
                  total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL ovf_full_4th got=%b exp=0", fifo_full); end
               end
               if (i == 4) begin
                  total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL ovf_full_5th got=%b exp=1", fifo_full); end
               end
            end
            trmt = 1'b0;
            total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL ovf_full_6th got=%b exp=1", fifo_full); end
         end
      join
      for (int f = 0; f < 5; f++) begin
         total++; if (got[f] !== exp_frame(d[f])) begin bad++; $display("FAIL ovf_frame%0d got=%b exp=%b", f, got[f], exp_frame(d[f])); end
         $display("overflow: frame %0d data=%h", f, got[f][8:1]);
      end
      zeros = 0;
      for (int n = 0; n < 30 * BD; n++) begin
         if (TX !== 1'b1) zeros++;
         @(negedge clk);
      end
      total++; if (zeros !== 0) begin bad++; $display("FAIL ovf_sixth_sent got=%0d exp=0 low cycles", zeros); end
      total++; if (tx_done !== 1'b1) begin bad++; $display("FAIL ovf_done got=%b exp=1", tx_done); end
   endtask

   task automatic test_flag_priority;
      push_byte(8'h5A);
      grab(1, 1'b1);
      total++; if (got[0] !== exp_frame(8'h5A)) begin bad++; $display("FAIL flag_frame got=%b exp=%b", got[0], exp_frame(8'h5A)); end
      total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL flag_clr_wins got=%b exp=0", tx_done); end
      @(negedge clk);
      total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL flag_clr_hold got=%b exp=0", tx_done); end
      $display("flag: clear on frame end, done=%b", tx_done);

      push_byte(8'hC3);
      grab(1, 1'b0);
      total++; if (tx_done !== 1'b1) begin bad++; $display("FAIL flag_set got=%b exp=1", tx_done); end
      clr_tx_done = 1'b1;
      @(negedge clk);
      clr_tx_done = 1'b0;
      total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL flag_clr_only got=%b exp=0", tx_done); end
      $display("flag: explicit clear, done=%b", tx_done);

      push_byte(8'h81);
      grab(1, 1'b0);
      total++; if (tx_done !== 1'b1) begin bad++; $display("FAIL flag_set2 got=%b exp=1", tx_done); end
      push_byte(8'h42);
      total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL flag_push_clears got=%b exp=0", tx_done); end
      grab(1, 1'b0);
      total++; if (got[0] !== exp_frame(8'h42)) begin bad++; $display("FAIL flag_frame2 got=%b exp=%b", got[0], exp_frame(8'h42)); end
      $display("flag: push clears, frame data=%h", got[0][8:1]);
   endtask

   task automatic test_reset_midframe;
      int lows;
      int busys;
      trmt    = 1'b1;
      tx_data = 8'h3C;
      @(negedge clk);
      tx_data = 8'hA1;
      @(negedge clk);                     // start bit now on the line (n=0)
      tx_data = 8'hB2;
      @(negedge clk);                     // n=1
      trmt = 1'b0;
      repeat (BD + BD / 2 - 1) @(negedge clk);
      total++; if (TX !== 1'b0) begin bad++; $display("FAIL rmid_bit1 got=%b exp=0", TX); end
      repeat (3 * BD) @(negedge clk);
      total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got=%b exp=1", tx_busy); end
      #2 rst = 1'b1;
      #1;
      total++; if (TX !== 1'b1)        begin bad++; $display("FAIL rmid_tx got=%b exp=1", TX); end
      total++; if (tx_busy !== 1'b0)   begin bad++; $display("FAIL rmid_busy got=%b exp=0", tx_busy); end
      total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL rmid_full got=%b exp=0", fifo_full); end
      repeat (2) @(negedge clk);
      rst   = 1'b0;
      lows  = 0;
      busys = 0;
      for (int n = 0; n < 30 * BD; n++) begin
         if (TX !== 1'b1) lows++;
         if (tx_busy !== 1'b0) busys++;
         @(negedge clk);
      end
      total++; if (lows !== 0)  begin bad++; $display("FAIL rmid_resumed_tx got=%0d exp=0 low cycles", lows); end
      total++; if (busys !== 0) begin bad++; $display("FAIL rmid_resumed_busy got=%0d exp=0 busy cycles", busys); end
      total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL rmid_done got=%b exp=0", tx_done); end
      $display("reset mid-frame: line stayed idle after release");
   endtask

   initial begin
      test_reset();
      test_single();
      test_loopback();
      test_back_to_back();
      test_overflow();
      test_flag_priority();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish total=%0d bad=%0d", total, bad);
      $fatal(1, "bench did not finish in time");
   end

endmodule
